pingpong_buf_ctrl: RTL and testbench

PINGPONG_BUF_CTRL -- requirements
Module: pingpong_buf_ctrl

---
 rtl/pingpong_buf_ctrl.sv | 99 +++++++++
 tb/tb_pingpong_buf_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pingpong_buf_ctrl.sv
// rtl/pingpong_buf_ctrl.sv - ping-pong tile write controller for two SRAM banks
// Producer words fill one bank per tile while the consumer drains the other.
module pingpong_buf_ctrl #(
   parameter int ADDR_WIDTH = 14,
   parameter int TILE_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic                  empty1,
   input  logic                  empty2,
   output logic                  wr_ready,
   output logic                  en1_n,
   output logic                  en2_n,
   output logic                  wr1_n,
   output logic                  wr2_n,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  full1,
   output logic                  full2,
   output logic                  bank_sel,
   output logic                  tile_done,
   output logic                  ovf_err
);

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(TILE_WORDS - 1);

   logic                  r_f1, r_f2;
   logic                  r_full1, r_full2;
   logic [ADDR_WIDTH-1:0] r_wcnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_bank_sel;
   logic                  r_en1_n, r_en2_n, r_wr1_n, r_wr2_n;
   logic                  r_tile_done;
   logic                  r_ovf;

   logic w_sel_flag, w_ready, w_accept, w_last;
   logic w_f1_nxt, w_f2_nxt;

   always_comb begin
      w_sel_flag = r_bank_sel ? r_f2 : r_f1;
      w_ready    = !rst && !w_sel_flag;
      w_accept   = wr_req && w_ready;
      w_last     = w_accept && (r_wcnt == LP_LAST);
      // A release and a completing tile may land together; each flag sees its own event.
      w_f1_nxt   = r_f1 && !empty1;
      w_f2_nxt   = r_f2 && !empty2;
      if (w_last && !r_bank_sel) w_f1_nxt = 1'b1;
      if (w_last &&  r_bank_sel) w_f2_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_f1        <= 1'b0;
         r_f2        <= 1'b0;
         r_full1     <= 1'b0;
         r_full2     <= 1'b0;
         r_wcnt      <= '0;
         r_addr      <= '0;
         r_bank_sel  <= 1'b0;
         r_en1_n     <= 1'b1;
         r_en2_n     <= 1'b1;
         r_wr1_n     <= 1'b1;
         r_wr2_n     <= 1'b1;
         r_tile_done <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_f1        <= w_f1_nxt;
         r_f2        <= w_f2_nxt;
         r_full1     <= r_f1;
         r_full2     <= r_f2;
         r_en1_n     <= !(w_accept && !r_bank_sel);
         r_wr1_n     <= !(w_accept && !r_bank_sel);
         r_en2_n     <= !(w_accept &&  r_bank_sel);
         r_wr2_n     <= !(w_accept &&  r_bank_sel);
         r_tile_done <= w_last;
         if (w_accept) begin
            r_addr <= r_wcnt;
            r_wcnt <= w_last ? '0 : r_wcnt + ADDR_WIDTH'(1);
         end
         if (w_last)
            r_bank_sel <= ~r_bank_sel;
         if (wr_req && !w_ready)
            r_ovf <= 1'b1;
      end
   end

   assign wr_ready  = w_ready;
   assign en1_n     = r_en1_n;
   assign en2_n     = r_en2_n;
   assign wr1_n     = r_wr1_n;
   assign wr2_n     = r_wr2_n;
   assign addr      = r_addr;
   assign full1     = r_full1;
   assign full2     = r_full2;
   assign bank_sel  = r_bank_sel;
   assign tile_done = r_tile_done;
   assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// tb/tb_pingpong_buf_ctrl.sv - self-checking bench for pingpong_buf_ctrl
module tb_pingpong_buf_ctrl;

   localparam int AW = 14;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst, wr_req, empty1, empty2;
   logic          wr_ready, en1_n, en2_n, wr1_n, wr2_n;
   logic          full1, full2, bank_sel, tile_done, ovf_err;
   logic [AW-1:0] addr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pingpong_buf_ctrl #(.ADDR_WIDTH(AW), .TILE_WORDS(TW)) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .empty1(empty1), .empty2(empty2),
      .wr_ready(wr_ready), .en1_n(en1_n), .en2_n(en2_n), .wr1_n(wr1_n), .wr2_n(wr2_n),
      .addr(addr), .full1(full1), .full2(full2), .bank_sel(bank_sel),
      .tile_done(tile_done), .ovf_err(ovf_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: which banks hold a tile, which bank fills next, words so far.
   bit m_flag[2];
   bit m_full[2];
   int m_bank, m_cnt, m_addr, m_strobe;
   bit m_done, m_ovf;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      bit ready, acc;
      bit nf[2];
      m_valid = 1'b1;
      if (rst) begin
         m_flag = '{0, 0}; m_full = '{0, 0};
         m_bank = 0; m_cnt = 0; m_addr = 0; m_strobe = -1;
         m_done = 0; m_ovf = 0;
      end else begin
         ready = !m_flag[m_bank];
         acc   = wr_req && ready;
         m_full = m_flag;
         nf[0] = m_flag[0] && !empty1;
         nf[1] = m_flag[1] && !empty2;
         m_done = 0; m_strobe = -1;
         if (acc) begin
            m_strobe = m_bank;
            m_addr   = m_cnt;
            if (m_cnt == TW - 1) begin
               nf[m_bank] = 1; m_cnt = 0; m_bank ^= 1; m_done = 1;
            end else begin
               m_cnt++;
            end
         end
         if (wr_req && !ready) m_ovf = 1;
         m_flag = nf;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("strobes", 32'({en1_n, wr1_n, en2_n, wr2_n}),
             32'({m_strobe != 0, m_strobe != 0, m_strobe != 1, m_strobe != 1}));
         chk("addr", 32'(addr), 32'(m_addr));
         chk("status", 32'({full1, full2, bank_sel, tile_done, ovf_err}),
             32'({m_full[0], m_full[1], m_bank[0], m_done, m_ovf}));
         chk("wr_ready", 32'(wr_ready), 32'(!rst && !m_flag[m_bank]));
         chk("excl", 32'(!(!en1_n && !en2_n) && !(!wr1_n && !wr2_n)), 32'(1));
      end
   end

   task automatic step(input bit w, input bit e1, input bit e2);
      wr_req = w; empty1 = e1; empty2 = e2;
      @(posedge clk);
      #1;
      wr_req = 0; empty1 = 0; empty2 = 0;
   endtask

   initial begin
      rst = 1; wr_req = 0; empty1 = 0; empty2 = 0;
      step(0, 0, 0); step(0, 0, 0);
      chk("rst_ready", 32'(wr_ready), 32'(0));
      chk("rst_strb", 32'({en1_n, wr1_n, en2_n, wr2_n}), 32'(4'b1111));
      chk("rst_addr", 32'(addr), 32'(0));
      chk("rst_stat", 32'({full1, full2, bank_sel, tile_done, ovf_err}), 32'(0));
      rst = 0; #1;
      chk("ready_out_of_rst", 32'(wr_ready), 32'(1));

      // basic fill of bank 1 then bank 2
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      chk("fill1_last", 32'({en1_n, wr1_n, addr[3:0], tile_done, bank_sel, full1}),
          32'({1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0}));
      step(0, 0, 0);
      chk("fill1_full", 32'({full1, tile_done, en1_n}), 32'(3'b101));
      step(1, 0, 0);
      chk("bank2_first", 32'({en2_n, wr2_n, en1_n, addr[3:0]}), 32'({3'b001, 4'd0}));
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      chk("bank2_done", 32'({bank_sel, tile_done}), 32'(2'b01));
      step(0, 0, 0);
      chk("both_full", 32'({full1, full2, wr_ready}), 32'(3'b110));

      // overflow while both full
      step(1, 0, 0);
      chk("ovf_set", 32'({ovf_err, en1_n, en2_n}), 32'(3'b111));
      step(0, 0, 0);
      chk("ovf_sticky", 32'(ovf_err), 32'(1));

      // release bank 1, resume at addr 0
      step(0, 1, 0);
      chk("rel1_ready", 32'({wr_ready, full1}), 32'(2'b11));
      step(0, 0, 0);
      chk("rel1_full", 32'(full1), 32'(0));
      step(1, 0, 0);
      chk("resume_addr0", 32'({en1_n, addr[3:0]}), 32'({1'b0, 4'd0}));
      step(1, 0, 0); step(1, 0, 0);

      // bank 1's last word coincides with release of bank 2
      step(1, 0, 1);
      chk("simul_a", 32'({wr_ready, bank_sel, tile_done, addr[3:0]}), 32'({3'b111, 4'd3}));
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      // bank 2's last word coincides with release of bank 1
      step(1, 1, 0);
      chk("simul_b", 32'({wr_ready, bank_sel, tile_done}), 32'(3'b101));

      // drain bank 2, then a spurious release mid-tile
      step(0, 0, 1); step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0);
      step(0, 0, 1);
      chk("spurious", 32'({full2, bank_sel, en2_n}), 32'(3'b001));
      step(1, 0, 0);
      chk("spurious_wcnt", 32'({en1_n, addr[3:0]}), 32'({1'b0, 4'd2}));

      // reset mid-tile
      rst = 1;
      step(0, 0, 0);
      chk("mid_rst", 32'({en1_n, wr1_n, en2_n, wr2_n, full1, full2, bank_sel, tile_done, ovf_err, wr_ready}),
          32'(10'b1111000000));
      chk("mid_rst_addr", 32'(addr), 32'(0));
      rst = 0;
      step(1, 0, 0);
      chk("post_rst_write", 32'({en1_n, wr1_n, en2_n, addr[3:0]}), 32'({3'b001, 4'd0}));

      // mixed pattern checked by the model
      for (int i = 0; i < 60; i++) step((i % 3) != 2, (i % 7) == 3, (i % 5) == 1);
      step(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
